frame_align_ctrl: RTL and testbench

FRAME_ALIGN_CTRL -- requirements
Module: frame_align_ctrl

---
 rtl/adc_frontend_pkg.sv | 17 +
 rtl/frame_align_ctrl_if.sv | 41 ++++
 rtl/frame_word_window.sv | 32 +++
 rtl/frame_align_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_frame_align_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_frontend_pkg.sv
// Shared types and constants for the ADC front-end frame alignment logic.
package adc_frontend_pkg;

  // Alignment controller states.
  typedef enum logic [2:0] {
    StIdle,
    StSearch,
    StSlip,
    StVerify,
    StLocked,
    StError
  } align_state_e;

  // Frame-lane word expected from the ADC, MSB first in time.
  localparam logic [7:0] FramePatternDefault = 8'hF0;

endpackage

// File: rtl/frame_align_ctrl_if.sv
// Frame-lane inputs and alignment status outputs of frame_align_ctrl.
// slip_count / lock_loss_count exist only with FRAME_ALIGN_STATS_EN defined.
interface frame_align_ctrl_if #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned WORD_BITS = 8
);
  localparam int unsigned PhaseW = $clog2(WORD_BITS / 2);

  logic              frame_rise;
  logic              frame_fall;
  logic              enable;
  logic              realign;
  logic [LANES-1:0]  bitslip_pulse;
  logic [PhaseW-1:0] word_phase;
  logic              word_strobe;
  logic              locked;
  logic              align_error;
`ifdef FRAME_ALIGN_STATS_EN
  logic [7:0]        slip_count;
  logic [7:0]        lock_loss_count;
`endif

  // Stimulus side: drives the frame lane and controls, observes status.
  modport master (
    output frame_rise, frame_fall, enable, realign,
`ifdef FRAME_ALIGN_STATS_EN
    input  slip_count, lock_loss_count,
`endif
    input  bitslip_pulse, word_phase, word_strobe, locked, align_error
  );

  // Controller side.
  modport slave (
    input  frame_rise, frame_fall, enable, realign,
`ifdef FRAME_ALIGN_STATS_EN
    output slip_count, lock_loss_count,
`endif
    output bitslip_pulse, word_phase, word_strobe, locked, align_error
  );

endinterface

// File: rtl/frame_word_window.sv
// Shift window over the DDR frame lane plus even/odd frame-pattern compares.
// Two bits enter per cycle, rise bit first; the MSB holds the oldest bit.
module frame_word_window
  import adc_frontend_pkg::*;
#(
  parameter int unsigned          WORD_BITS = 8,
  parameter logic [WORD_BITS-1:0] PATTERN   = FramePatternDefault
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rise,
  input  logic i_fall,
  output logic o_even_hit,
  output logic o_odd_hit
);

  logic [WORD_BITS:0] r_window;

  // Shift in one rise/fall pair per cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_window <= '0;
    end else begin
      r_window <= {r_window[WORD_BITS-2:0], i_rise, i_fall};
    end
  end

  // Even hit: word boundary falls on a pair edge. Odd hit: it is one bit late.
  assign o_even_hit = (r_window[WORD_BITS-1:0] == PATTERN);
  assign o_odd_hit  = (r_window[WORD_BITS:1] == PATTERN);

endmodule

// File: rtl/frame_align_ctrl.sv
// Frame alignment controller: finds the word boundary on the ADC frame lane,
// requests bitslips until the boundary sits on a pair edge, then tracks lock.
// Optional statistics outputs are enabled by defining FRAME_ALIGN_STATS_EN.
module frame_align_ctrl
  import adc_frontend_pkg::*;
#(
  parameter int unsigned          LANES         = 8,
  parameter int unsigned          WORD_BITS     = 8,
  parameter logic [WORD_BITS-1:0] FRAME_PATTERN = FramePatternDefault,
  parameter int unsigned          LOCK_COUNT    = 16,
  parameter int unsigned          MISS_LIMIT    = 4,
  parameter int unsigned          SETTLE_CYCLES = 8
) (
  input  logic              dco_clk,
  input  logic              rst_n,
  frame_align_ctrl_if.slave io_bus
);

  localparam int unsigned WordPairs   = WORD_BITS / 2;
  localparam int unsigned PhaseW      = $clog2(WordPairs);
  localparam int unsigned MaxAttempts = 2;
  localparam int unsigned EvalEnd     = 2 * WordPairs;
  localparam int unsigned TimerMax    = (EvalEnd > SETTLE_CYCLES) ? EvalEnd : SETTLE_CYCLES;
  localparam int unsigned TimerW      = $clog2(TimerMax + 1);
  localparam int unsigned GoodW       = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW       = $clog2(MISS_LIMIT + 1);
  localparam int unsigned AttW        = $clog2(MaxAttempts + 1);

  localparam logic [PhaseW-1:0] PhaseLast  = PhaseW'(WordPairs - 1);
  // Search timer: 0..WordPairs fill the window, WordPairs+1..2*WordPairs evaluate.
  localparam logic [TimerW-1:0] FillLast   = TimerW'(WordPairs);
  localparam logic [TimerW-1:0] EvalLast   = TimerW'(EvalEnd);
  localparam logic [TimerW-1:0] SettleLast = TimerW'(SETTLE_CYCLES);
  localparam logic [GoodW-1:0]  GoodMax    = GoodW'(LOCK_COUNT);
  localparam logic [GoodW-1:0]  GoodLast   = GoodW'(LOCK_COUNT - 1);
  localparam logic [MissW-1:0]  MissLast   = MissW'(MISS_LIMIT - 1);
  localparam logic [AttW-1:0]   AttMax     = AttW'(MaxAttempts);

  align_state_e      r_state;
  logic [TimerW-1:0] r_timer;
  logic [AttW-1:0]   r_attempts;
  logic [GoodW-1:0]  r_good;
  logic [MissW-1:0]  r_miss;
  logic [PhaseW-1:0] r_cnt;
  logic [PhaseW-1:0] r_word_phase;
  logic [LANES-1:0]  r_bitslip;
  logic              r_strobe;
  logic              r_locked;
  logic              r_align_err;

  logic w_even_hit;
  logic w_odd_hit;
  logic w_boundary;
  // The odd compare is informational: a failed search slips whether or not it hit.
  logic w_unused_odd_hit;

  frame_word_window #(
    .WORD_BITS (WORD_BITS),
    .PATTERN   (FRAME_PATTERN)
  ) u_window (
    .i_clk      (dco_clk),
    .i_rst_n    (rst_n),
    .i_rise     (io_bus.frame_rise),
    .i_fall     (io_bus.frame_fall),
    .o_even_hit (w_even_hit),
    .o_odd_hit  (w_odd_hit)
  );

  assign w_unused_odd_hit = w_odd_hit;
  assign w_boundary       = (r_cnt == r_word_phase);

  // Free-running pair phase counter; held at zero while disabled.
  always_ff @(posedge dco_clk) begin
    if (!rst_n || !io_bus.enable) begin
      r_cnt <= '0;
    end else if (r_cnt == PhaseLast) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Alignment FSM with registered outputs; priority reset > realign > disable.
  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_timer      <= '0;
      r_attempts   <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_word_phase <= '0;
      r_bitslip    <= '0;
      r_strobe     <= 1'b0;
      r_locked     <= 1'b0;
      r_align_err  <= 1'b0;
    end else if (io_bus.realign) begin
      r_state     <= StSearch;
      r_timer     <= '0;
      r_attempts  <= '0;
      r_good      <= '0;
      r_miss      <= '0;
      r_bitslip   <= '0;
      r_strobe    <= 1'b0;
      r_locked    <= 1'b0;
      r_align_err <= 1'b0;
    end else if (!io_bus.enable) begin
      r_state      <= StIdle;
      r_timer      <= '0;
      r_attempts   <= '0;
      r_good       <= '0;
      r_miss       <= '0;
      r_word_phase <= '0;
      r_bitslip    <= '0;
      r_strobe     <= 1'b0;
      r_locked     <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_bitslip <= '0;
      r_strobe  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_state <= StSearch;
          r_timer <= '0;
        end
        StSearch: begin
          if (r_timer <= FillLast) begin
            r_timer <= r_timer + 1'b1;
          end else if (w_even_hit) begin
            r_word_phase <= r_cnt;
            r_good       <= '0;
            r_state      <= StVerify;
          end else if (r_timer == EvalLast) begin
            r_timer <= '0;
            if (r_attempts == AttMax) begin
              r_state     <= StError;
              r_align_err <= 1'b1;
            end else begin
              r_attempts <= r_attempts + 1'b1;
              r_bitslip  <= '1;
              r_state    <= StSlip;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StSlip: begin
          // First SLIP cycle carries the pulse; the rest let the deserializer settle.
          if (r_timer == SettleLast) begin
            r_timer <= '0;
            r_state <= StSearch;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StVerify: begin
          if (w_boundary) begin
            r_strobe <= 1'b1;
            if (w_even_hit) begin
              if (r_good == GoodLast) begin
                r_good   <= GoodMax;
                r_miss   <= '0;
                r_locked <= 1'b1;
                r_state  <= StLocked;
              end else begin
                r_good <= r_good + 1'b1;
              end
            end else begin
              r_good  <= '0;
              r_timer <= '0;
              r_state <= StSearch;
            end
          end
        end
        StLocked: begin
          if (w_boundary) begin
            r_strobe <= 1'b1;
            if (w_even_hit) begin
              r_miss <= '0;
            end else if (r_miss == MissLast) begin
              r_state    <= StSearch;
              r_timer    <= '0;
              r_attempts <= '0;
              r_good     <= '0;
              r_miss     <= '0;
              r_locked   <= 1'b0;
            end else begin
              r_miss <= r_miss + 1'b1;
            end
          end
        end
        StError: begin
          r_align_err <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign io_bus.bitslip_pulse = r_bitslip;
  assign io_bus.word_phase    = r_word_phase;
  assign io_bus.word_strobe   = r_strobe;
  assign io_bus.locked        = r_locked;
  assign io_bus.align_error   = r_align_err;

`ifdef FRAME_ALIGN_STATS_EN
  logic [7:0] r_slip_count;
  logic [7:0] r_lock_loss_count;
  logic       w_lock_drop;

  // Any exit from LOCKED back into SEARCH: realign or too many boundary misses.
  assign w_lock_drop = (r_state == StLocked) &&
                       (io_bus.realign ||
                        (io_bus.enable && w_boundary && !w_even_hit && (r_miss == MissLast)));

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      r_slip_count      <= '0;
      r_lock_loss_count <= '0;
    end else begin
      if (r_bitslip[0] && (r_slip_count != 8'hFF)) begin
        r_slip_count <= r_slip_count + 1'b1;
      end
      if (w_lock_drop && (r_lock_loss_count != 8'hFF)) begin
        r_lock_loss_count <= r_lock_loss_count + 1'b1;
      end
    end
  end

  assign io_bus.slip_count      = r_slip_count;
  assign io_bus.lock_loss_count = r_lock_loss_count;
`endif

endmodule

// File: tb/tb_frame_align_ctrl.sv
// Directed bench for frame_align_ctrl (WORD_BITS=8, pattern F0, N=4, LOCK_COUNT=16).
module tb_frame_align_ctrl;

  logic dco_clk = 1'b0;
  logic rst_n   = 1'b0;

  always #5 dco_clk = ~dco_clk;

  frame_align_ctrl_if #(.LANES(8), .WORD_BITS(8)) bus ();

  frame_align_ctrl #(
    .LANES         (8),
    .WORD_BITS     (8),
    .FRAME_PATTERN (8'hF0),
    .LOCK_COUNT    (16),
    .MISS_LIMIT    (4),
    .SETTLE_CYCLES (8)
  ) dut (
    .dco_clk (dco_clk),
    .rst_n   (rst_n),
    .io_bus  (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Serial stream model: ptr is the pattern bit index of the next rise bit.
  logic [7:0] pat = 8'hF0;
  int  ptr = 0;
  bit  zero_mode = 1'b0;
  bit  follow_slip = 1'b0;
  int  corrupt_left = 0;
  int  corrupt_cyc = 0;

  // Samples taken #1 after each rising edge.
  logic [7:0] s_slip;
  logic [1:0] s_phase;
  logic       s_strobe;
  logic       s_locked;
  logic       s_err;
  logic [7:0] last_slip;
  bit         prev_slip_nz;
  int         slip_cycles;
  int         slip_edges;
  int         strobes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic r;
    logic f;
    if (corrupt_cyc == 0 && corrupt_left > 0 && (ptr % 8) == 0) begin
      corrupt_cyc  = 4;
      corrupt_left = corrupt_left - 1;
    end
    r = pat[7 - (ptr % 8)];
    f = pat[7 - ((ptr + 1) % 8)];
    if (zero_mode || corrupt_cyc > 0) begin
      r = 1'b0;
      f = 1'b0;
    end
    if (corrupt_cyc > 0) corrupt_cyc = corrupt_cyc - 1;
    bus.frame_rise = r;
    bus.frame_fall = f;
    ptr = ptr + 2;
  endtask

  task automatic tick();
    @(posedge dco_clk);
    #1;
    s_slip   = bus.bitslip_pulse;
    s_phase  = bus.word_phase;
    s_strobe = bus.word_strobe;
    s_locked = bus.locked;
    s_err    = bus.align_error;
    if (s_slip != 8'h00) begin
      slip_cycles++;
      last_slip = s_slip;
      if (!prev_slip_nz) slip_edges++;
      // The bitslip stage drops one bit in response.
      if (follow_slip) ptr = ptr + 1;
    end
    prev_slip_nz = (s_slip != 8'h00);
    if (s_strobe) strobes++;
    drive();
  endtask

  task automatic clear_stats();
    slip_cycles  = 0;
    slip_edges   = 0;
    strobes      = 0;
    last_slip    = 8'h00;
    prev_slip_nz = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.enable  = 1'b0;
    bus.realign = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_stats();
  endtask

  // lat = cycles from the edge that samples enable to the edge that shows locked.
  task automatic wait_lock(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (s_locked) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int t_prev;
    int ng;
    int lost;
    int found;
    int slips_before;

    bus.frame_rise = 1'b0;
    bus.frame_fall = 1'b0;
    bus.enable     = 1'b0;
    bus.realign    = 1'b0;
    clear_stats();

    // Reset state.
    do_reset();
    tick();
    check("rst_bitslip", s_slip, 8'h00);
    check("rst_word_phase", s_phase, 2'd0);
    check("rst_word_strobe", s_strobe, 1'b0);
    check("rst_locked", s_locked, 1'b0);
    check("rst_align_error", s_err, 1'b0);

    // Aligned repeating F0.
    clear_stats();
    bus.enable = 1'b1;
    wait_lock(120, lat);
    check("aligned_locked", s_locked, 1'b1);
    check("aligned_lock_le_73", (lat >= 0 && lat <= 73), 1'b1);
    check("aligned_no_slip", slip_cycles, 0);
    t_prev = -1;
    ng = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (s_strobe) begin
        if (t_prev >= 0 && ng < 3) begin
          check("strobe_gap", i - t_prev, 4);
          ng++;
        end
        t_prev = i;
      end
    end
    check("strobe_gaps_seen", ng, 3);

    // Three bad words then a good one: lock held.
    while ((ptr % 8) != 0) tick();
    corrupt_left = 3;
    lost = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_locked) lost++;
      if (i == 5) check("bad_word_strobe", s_strobe, 1'b1);
    end
    check("locked_through_3_bad", lost, 0);

    // Four bad words: lock drops the cycle after the 4th boundary.
    corrupt_left = 4;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 16) check("locked_before_4th_bad", s_locked, 1'b1);
      if (i == 17) begin
        check("unlocked_after_4th_bad", s_locked, 1'b0);
        check("strobe_at_4th_bad", s_strobe, 1'b1);
      end
    end
`ifdef FRAME_ALIGN_STATS_EN
    check("stats_lock_loss_1", bus.lock_loss_count, 8'd1);
`endif
    wait_lock(120, lat);
    check("relock_after_search", s_locked, 1'b1);
    check("relock_no_slip", slip_cycles, 0);

    // Realign while locked.
    bus.realign = 1'b1;
    tick();
    bus.realign = 1'b0;
    check("realign_unlocks", s_locked, 1'b0);

    // Reset for one cycle while in VERIFY (strobing but not yet locked).
    found = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_strobe && !s_locked) begin
        found = 1;
        break;
      end
    end
    check("verify_reached", found, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midverify_rst_bitslip", s_slip, 8'h00);
    check("midverify_rst_phase", s_phase, 2'd0);
    check("midverify_rst_strobe", s_strobe, 1'b0);
    check("midverify_rst_locked", s_locked, 1'b0);
    check("midverify_rst_error", s_err, 1'b0);

    // Stream delayed one bit; the model applies each requested slip.
    do_reset();
    ptr = 7;
    follow_slip = 1'b1;
    bus.enable = 1'b1;
    wait_lock(250, lat);
    check("delayed_locked", s_locked, 1'b1);
    check("delayed_slip_cycles", slip_cycles, 1);
    check("delayed_slip_pulses", slip_edges, 1);
    check("delayed_slip_value", last_slip, 8'hFF);
    follow_slip = 1'b0;

    // Disable while locked.
    bus.enable = 1'b0;
    tick();
    check("disable_locked", s_locked, 1'b0);
    check("disable_strobe", s_strobe, 1'b0);
    check("disable_phase", s_phase, 2'd0);

    // Frame lane stuck at 0: two slips, then error.
    do_reset();
    zero_mode = 1'b1;
    bus.enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (s_err) break;
    end
    check("zero_align_error", s_err, 1'b1);
    check("zero_slip_pulses", slip_edges, 2);
    check("zero_slip_cycles", slip_cycles, 2);
    check("zero_locked", s_locked, 1'b0);
    check("zero_no_strobe", strobes, 0);
    repeat (20) tick();
    check("zero_error_held", s_err, 1'b1);
    check("zero_no_more_slips", slip_cycles, 2);
`ifdef FRAME_ALIGN_STATS_EN
    check("stats_slip_count", bus.slip_count, 8'd2);
    check("stats_lock_loss_0", bus.lock_loss_count, 8'd0);
`endif
    bus.realign = 1'b1;
    tick();
    bus.realign = 1'b0;
    check("realign_clears_error", s_err, 1'b0);

    // Reset in the middle of SLIP: no further pulses.
    do_reset();
    bus.enable = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (s_slip != 8'h00) begin
        found = 1;
        break;
      end
    end
    check("midslip_first_pulse", found, 1);
    tick();
    rst_n = 1'b0;
    slips_before = slip_cycles;
    repeat (12) tick();
    check("midslip_no_pulse", slip_cycles - slips_before, 0);
    check("midslip_error", s_err, 1'b0);
    rst_n = 1'b1;
    zero_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
